// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, plus MFHI/MFLO/MTHI/MTLO service.
// Latency: op accepted at edge N, HI/LO written and BUSY_OUT low after edge N+33.
// Backpressure: STALL_OUT holds any HI/LO op while busy; FREEZE blocks acceptance only.
module exe_muldiv (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREEZE,
    input  logic [5:0]  ALU_control1,
    input  logic [31:0] readDataA1,
    input  logic [31:0] readDataB1,
    output logic [31:0] mfResult1_OUT,
    output logic        STALL_OUT,
    output logic        BUSY_OUT,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;      // multiplicand magnitude
    logic [31:0] r_b;      // divisor magnitude
    logic [63:0] r_prod;   // mul: {partial sum, multiplier}; div: [31:0] dividend -> quotient
    logic [31:0] r_rem;    // divide partial remainder
    logic        r_neg;    // product / quotient must be negated
    logic        r_dneg;   // dividend was negative: remainder takes its sign
    logic        r_div;
    logic        r_dz;     // divide by zero: quotient forced to all ones
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_muldiv;
    logic        w_hilo_op;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_madd;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Operation decode; codes 0110xx are mul/div, 0100xx are HI/LO moves.
    assign w_is_muldiv = (ALU_control1 == OP_MULT) || (ALU_control1 == OP_MULTU) ||
                         (ALU_control1 == OP_DIV)  || (ALU_control1 == OP_DIVU);
    assign w_hilo_op   = w_is_muldiv ||
                         (ALU_control1 == OP_MFHI) || (ALU_control1 == OP_MTHI) ||
                         (ALU_control1 == OP_MFLO) || (ALU_control1 == OP_MTLO);
    assign w_signed    = (ALU_control1 == OP_MULT) || (ALU_control1 == OP_DIV);
    assign w_a_neg     = w_signed & readDataA1[31];
    assign w_b_neg     = w_signed & readDataB1[31];
    assign w_a_mag     = w_a_neg ? (~readDataA1 + 32'd1) : readDataA1;
    assign w_b_mag     = w_b_neg ? (~readDataB1 + 32'd1) : readDataB1;

    // Multiply step: add multiplicand into the upper half when the multiplier LSB is set.
    assign w_madd      = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_a : 32'd0)};

    // Restoring divide step. The true difference is below the divisor, so 32 bits suffice.
    assign w_rem_sh    = {r_rem, r_prod[31]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_b});
    assign w_sub       = w_rem_sh[31:0] - r_b;

    // Sign correction applied in the FIX state.
    assign w_prod_fix  = r_neg ? (~r_prod + 64'd1) : r_prod;
    assign w_quo_fix   = r_dz  ? 32'hFFFF_FFFF :
                         (r_neg ? (~r_prod[31:0] + 32'd1) : r_prod[31:0]);
    assign w_rem_fix   = r_dneg ? (~r_rem + 32'd1) : r_rem;

    assign BUSY_OUT    = (r_state != S_IDLE);
    assign STALL_OUT   = BUSY_OUT & w_hilo_op;
    assign HI_OUT      = r_hi;
    assign LO_OUT      = r_lo;

    // Move-from result: current HI/LO only, nothing forwarded from an in-flight op.
    always_comb begin
        mfResult1_OUT = 32'd0;
        if (ALU_control1 == OP_MFHI) begin
            mfResult1_OUT = r_hi;
        end else if (ALU_control1 == OP_MFLO) begin
            mfResult1_OUT = r_lo;
        end
    end

    // Control FSM and datapath: accept in IDLE, 32 radix-2 steps in RUN, sign fix in FIX.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_prod  <= 64'd0;
            r_rem   <= 32'd0;
            r_neg   <= 1'b0;
            r_dneg  <= 1'b0;
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!FREEZE) begin
                        if (w_is_muldiv) begin
                            r_a     <= w_a_mag;
                            r_b     <= w_b_mag;
                            r_prod  <= {32'd0, (ALU_control1[1] ? w_a_mag : w_b_mag)};
                            r_rem   <= 32'd0;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_dneg  <= w_a_neg;
                            r_div   <= ALU_control1[1];
                            r_dz    <= ALU_control1[1] & (readDataB1 == 32'd0);
                            r_cnt   <= 5'd0;
                            r_state <= S_RUN;
                        end else if (ALU_control1 == OP_MTHI) begin
                            r_hi <= readDataA1;
                        end else if (ALU_control1 == OP_MTLO) begin
                            r_lo <= readDataA1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_div) begin
                        r_rem  <= w_ge ? w_sub : w_rem_sh[31:0];
                        r_prod <= {r_prod[63:32], r_prod[30:0], w_ge};
                    end else begin
                        r_prod <= {w_madd, r_prod[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
